scaler_cfg_ctrl: RTL and testbench
==================================

# scaler_cfg_ctrl

Frame-synchronous configuration controller for the video scaler path (image cut, line FIFO, stream scaler, blank fill). It accepts crop-window, output-resolution and algorithm settings from the CPU register interface and validates them. It computes the Q4.14 x/y scale factors with a shared serial divider, replacing the combinational divide. The complete configuration set is applied atomically on the next frame start, so the datapath never sees a mixed old/new configuration inside a frame.

## Interface
- X_RES_WIDTH, 11, width of x coordinates and resolutions
- Y_RES_WIDTH, 11, width of y coordinates and resolutions
- SCALE_INT_BITS, 4, integer bits of scale factor
- SCALE_FRAC_BITS, 14, fraction bits of scale factor
- SCALE_BITS, SCALE_INT_BITS+SCALE_FRAC_BITS, scale factor width
- DIV_BITS, max(X_RES_WIDTH,Y_RES_WIDTH)+1+SCALE_FRAC_BITS, dividend width and iterations per division (26)

Ports:
- clk  in  1  scaler clock domain (clk_2x of the scaler path); single clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_start_x / cfg_end_x  in  X_RES_WIDTH  requested crop window, x
- cfg_start_y / cfg_end_y  in  Y_RES_WIDTH  requested crop window, y
- cfg_out_x_res / cfg_out_y_res  in  X/Y_RES_WIDTH  requested output resolution minus 1
- cfg_nearest  in  1  algorithm select (1 = nearest neighbour)
- cfg_wr  in  1  one-cycle write strobe, samples all cfg_* inputs
- frame_start  in  1  one-cycle pulse at input vsync rising edge
- cfg_busy  out  1  high while checking or dividing; cfg_wr is ignored while high
- cfg_err  out  1  sticky; set by a rejected write, cleared by the next accepted write
- cfg_pending  out  1  a validated set is waiting for frame_start
- cfg_applied  out  1  one-cycle pulse when active registers update
- scaler_en  out  1  low until the first apply, then high
- start_x, end_x, start_y, end_y  out  X/Y_RES_WIDTH  active crop window
- input_x_res / input_y_res  out  X/Y_RES_WIDTH  active end−start−1
- output_x_res / output_y_res  out  X/Y_RES_WIDTH  active output resolution minus 1
- x_scale / y_scale  out  SCALE_BITS  active Q4.14 scale factors
- nearest_neighbor  out  1  active algorithm select

## Operation
- States: IDLE, CHECK, DIV_X, DIV_Y, PEND.
- **IDLE.** cfg_wr captures all cfg_* inputs into staging registers and moves to CHECK.
- **CHECK (1 cycle).** Computes the numerators and divisors:
  - in_x1 = end_x−start_x and in_y1 = end_y−start_y (resolution).
  - ox1 = out_x+1 and oy1 = out_y+1.
  - The set is rejected if end_x ≤ start_x, or end_y ≤ start_y, or in_x1 ≥ 16·ox1, or in_y1 ≥ 16·oy1 (scale overflow).
  - On reject: set cfg_err and go to IDLE. Active and pending registers are unchanged.
  - On accept: clear cfg_err and go to DIV_X.
- **DIV_X / DIV_Y.** Restoring division of (in1 << SCALE_FRAC_BITS) by o1 over DIV_BITS cycles each, one quotient bit per cycle, MSB first.
  - The quotient is truncated (floor) to SCALE_BITS; the overflow check guarantees the upper bits are zero.
  - Results go to the pending registers, then the state moves to PEND.
- **PEND.** cfg_pending is high.
  - On frame_start, all pending values copy to the active outputs in the same edge, cfg_applied pulses, scaler_en is set, and the state moves to IDLE.
  - A cfg_wr in PEND discards the pending set and re-enters CHECK with the new values.
- If frame_start and cfg_wr coincide in PEND, the apply wins and the cfg_wr is ignored.
- frame_start outside PEND has no effect. A set finishing division after a frame_start waits for the following one.

## Timing
- Reset: state IDLE. All outputs are 0: every active register, x_scale, y_scale, cfg_busy, cfg_err, cfg_pending, cfg_applied and scaler_en.
- cfg_wr at cycle 0: CHECK at cycle 1, DIV_X cycles 2..27, DIV_Y cycles 28..53, PEND from cycle 54 (DIV_BITS = 26).
- Earliest apply: frame_start at cycle 54 → active outputs and cfg_applied valid at cycle 55.
- cfg_busy is high exactly in CHECK/DIV_X/DIV_Y (cycles 1..53).
- Active outputs are registered and change only on the cfg_applied cycle.
- Reset asserted mid-division or in PEND aborts the operation and clears everything.

## Structure
- Shared package scaler_cfg_pkg holds:
  - the state encoding;
  - the SCALE_* and DIV_BITS constants;
  - a struct typedef for the full configuration set, used for staging, pending and active registers.
- Sub-module serial_divider: unsigned restoring divider with a start/done handshake and DIV_BITS-cycle latency. It is instantiated once and shared by DIV_X and DIV_Y.

## Test plan
- Crop 0..1280 × 0..720, output 1919×1079, frame_start after PEND → x_scale = y_scale = 0x2AAA, input_x_res = 1279, input_y_res = 719, cfg_applied one pulse, scaler_en = 1.
- Identity: crop 0..1920 × 0..1080, output 1919×1079 → x_scale = y_scale = 0x4000.
- Overflow: crop width 1920, cfg_out_x_res = 99 → cfg_err = 1, state IDLE by cycle 2, active outputs unchanged, no cfg_applied.
- Invalid window: end_x = start_x = 100 → cfg_err = 1. A subsequent valid write clears cfg_err at CHECK.
- frame_start at cycle 30 (mid-division) → no apply. Second frame_start at cycle 80 → apply at cycle 81. cfg_wr at cycle 10 is ignored (cfg_busy = 1).
- Reset pulse while in PEND → all outputs 0, cfg_pending = 0. A frame_start afterwards produces no cfg_applied.

Source files
------------

// File: rtl/scaler_cfg_pkg.sv
// scaler_cfg_pkg: shared constants, FSM states and config-set struct for the scaler config path
package scaler_cfg_pkg;
  localparam int X_RES_WIDTH = 11;
  localparam int Y_RES_WIDTH = 11;
  localparam int SCALE_INT_BITS = 4;
  localparam int SCALE_FRAC_BITS = 14;
  localparam int SCALE_BITS = SCALE_INT_BITS + SCALE_FRAC_BITS;
  localparam int RES_W = X_RES_WIDTH > Y_RES_WIDTH ? X_RES_WIDTH : Y_RES_WIDTH;
  localparam int DIV_BITS = RES_W + 1 + SCALE_FRAC_BITS;
  typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, PEND} state_t;
  typedef struct packed {
    logic [X_RES_WIDTH-1:0] start_x;
    logic [X_RES_WIDTH-1:0] end_x;
    logic [Y_RES_WIDTH-1:0] start_y;
    logic [Y_RES_WIDTH-1:0] end_y;
    logic [X_RES_WIDTH-1:0] input_x_res;
    logic [Y_RES_WIDTH-1:0] input_y_res;
    logic [X_RES_WIDTH-1:0] output_x_res;
    logic [Y_RES_WIDTH-1:0] output_y_res;
    logic [SCALE_BITS-1:0]  x_scale;
    logic [SCALE_BITS-1:0]  y_scale;
    logic                   nearest_neighbor;
  } cfg_t;
endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle MSB first, N-cycle latency
module serial_divider
  import scaler_cfg_pkg::*;
#(
  parameter int N  = DIV_BITS,
  parameter int D  = RES_W + 1,
  parameter int QW = SCALE_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  dividend,
  input  logic [D-1:0]  divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic [D-1:0] rem, dvs;
  logic [D:0] rem_sh;
  logic [N-1:0] q, q_nx;
  logic [CW-1:0] cnt;
  logic ge;
  // q shifts dividend bits out of the top while quotient bits enter at the bottom
  assign rem_sh = {rem, q[N-1]};
  assign ge = rem_sh >= {1'b0, dvs};
  assign q_nx = {q[N-2:0], ge};
  assign done = cnt == CW'(1);
  assign quotient = q_nx[QW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      dvs <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      dvs <= divisor;
      q   <= dividend;
      cnt <= CW'(N);
    end else if (cnt != '0) begin
      rem <= ge ? D'(rem_sh - {1'b0, dvs}) : rem_sh[D-1:0];
      q   <= q_nx;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl: validates scaler config, computes Q4.14 scale factors serially, applies on frame start
module scaler_cfg_ctrl
  import scaler_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [X_RES_WIDTH-1:0] cfg_start_x,
  input  logic [X_RES_WIDTH-1:0] cfg_end_x,
  input  logic [Y_RES_WIDTH-1:0] cfg_start_y,
  input  logic [Y_RES_WIDTH-1:0] cfg_end_y,
  input  logic [X_RES_WIDTH-1:0] cfg_out_x_res,
  input  logic [Y_RES_WIDTH-1:0] cfg_out_y_res,
  input  logic                   cfg_nearest,
  input  logic                   cfg_wr,
  input  logic                   frame_start,
  output logic                   cfg_busy,
  output logic                   cfg_err,
  output logic                   cfg_pending,
  output logic                   cfg_applied,
  output logic                   scaler_en,
  output logic [X_RES_WIDTH-1:0] start_x,
  output logic [X_RES_WIDTH-1:0] end_x,
  output logic [Y_RES_WIDTH-1:0] start_y,
  output logic [Y_RES_WIDTH-1:0] end_y,
  output logic [X_RES_WIDTH-1:0] input_x_res,
  output logic [Y_RES_WIDTH-1:0] input_y_res,
  output logic [X_RES_WIDTH-1:0] output_x_res,
  output logic [Y_RES_WIDTH-1:0] output_y_res,
  output logic [SCALE_BITS-1:0]  x_scale,
  output logic [SCALE_BITS-1:0]  y_scale,
  output logic                   nearest_neighbor
);
  state_t state, state_nx;
  cfg_t stg, pnd, act;
  logic [X_RES_WIDTH-1:0] in_x1;
  logic [Y_RES_WIDTH-1:0] in_y1;
  logic [X_RES_WIDTH:0] ox1;
  logic [Y_RES_WIDTH:0] oy1;
  logic bad, div_start, div_done, take_wr;
  logic [DIV_BITS-1:0] dividend;
  logic [RES_W:0] divisor;
  logic [SCALE_BITS-1:0] quotient;
  assign in_x1 = stg.end_x - stg.start_x;
  assign in_y1 = stg.end_y - stg.start_y;
  assign ox1 = (X_RES_WIDTH+1)'(stg.output_x_res) + (X_RES_WIDTH+1)'(1);
  assign oy1 = (Y_RES_WIDTH+1)'(stg.output_y_res) + (Y_RES_WIDTH+1)'(1);
  // ratio must stay below 2^SCALE_INT_BITS so the quotient fits SCALE_BITS
  assign bad = stg.end_x <= stg.start_x || stg.end_y <= stg.start_y
    || (X_RES_WIDTH+1+SCALE_INT_BITS)'(in_x1) >= {ox1, {SCALE_INT_BITS{1'b0}}}
    || (Y_RES_WIDTH+1+SCALE_INT_BITS)'(in_y1) >= {oy1, {SCALE_INT_BITS{1'b0}}};
  assign dividend = state == CHECK ? DIV_BITS'({in_x1, {SCALE_FRAC_BITS{1'b0}}})
                                   : DIV_BITS'({in_y1, {SCALE_FRAC_BITS{1'b0}}});
  assign divisor = state == CHECK ? (RES_W+1)'(ox1) : (RES_W+1)'(oy1);
  assign take_wr = cfg_wr && (state == IDLE || (state == PEND && !frame_start));
  assign cfg_busy = state == CHECK || state == DIV_X || state == DIV_Y;
  assign cfg_pending = state == PEND;
  serial_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    div_start = 1'b0;
    case (state)
      IDLE: state_nx = cfg_wr ? CHECK : IDLE;
      CHECK: begin
        state_nx = bad ? IDLE : DIV_X;
        div_start = !bad;
      end
      DIV_X: begin
        state_nx = div_done ? DIV_Y : DIV_X;
        div_start = div_done;
      end
      DIV_Y: state_nx = div_done ? PEND : DIV_Y;
      PEND: state_nx = frame_start ? IDLE : cfg_wr ? CHECK : PEND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg <= '0;
      pnd <= '0;
      act <= '0;
      cfg_err <= 1'b0;
      cfg_applied <= 1'b0;
      scaler_en <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      if (take_wr) begin
        stg.start_x <= cfg_start_x;
        stg.end_x <= cfg_end_x;
        stg.start_y <= cfg_start_y;
        stg.end_y <= cfg_end_y;
        stg.output_x_res <= cfg_out_x_res;
        stg.output_y_res <= cfg_out_y_res;
        stg.nearest_neighbor <= cfg_nearest;
      end
      if (state == CHECK) begin
        cfg_err <= bad;
        stg.input_x_res <= in_x1 - X_RES_WIDTH'(1);
        stg.input_y_res <= in_y1 - Y_RES_WIDTH'(1);
      end
      if (state == DIV_X && div_done) stg.x_scale <= quotient;
      if (state == DIV_Y && div_done) begin
        pnd <= stg;
        pnd.y_scale <= quotient;
      end
      if (state == PEND && frame_start) begin
        act <= pnd;
        cfg_applied <= 1'b1;
        scaler_en <= 1'b1;
      end
    end
  assign start_x = act.start_x;
  assign end_x = act.end_x;
  assign start_y = act.start_y;
  assign end_y = act.end_y;
  assign input_x_res = act.input_x_res;
  assign input_y_res = act.input_y_res;
  assign output_x_res = act.output_x_res;
  assign output_y_res = act.output_y_res;
  assign x_scale = act.x_scale;
  assign y_scale = act.y_scale;
  assign nearest_neighbor = act.nearest_neighbor;
endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// tb_scaler_cfg_ctrl: directed checks of validation, serial scale division and frame-synchronous apply
module tb_scaler_cfg_ctrl;
  import scaler_cfg_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [X_RES_WIDTH-1:0] cfg_start_x = '0, cfg_end_x = '0, cfg_out_x_res = '0;
  logic [Y_RES_WIDTH-1:0] cfg_start_y = '0, cfg_end_y = '0, cfg_out_y_res = '0;
  logic cfg_nearest = 1'b0, cfg_wr = 1'b0, frame_start = 1'b0;
  logic cfg_busy, cfg_err, cfg_pending, cfg_applied, scaler_en, nearest_neighbor;
  logic [X_RES_WIDTH-1:0] start_x, end_x, input_x_res, output_x_res;
  logic [Y_RES_WIDTH-1:0] start_y, end_y, input_y_res, output_y_res;
  logic [SCALE_BITS-1:0] x_scale, y_scale;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  scaler_cfg_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start_x      (cfg_start_x),
    .cfg_end_x        (cfg_end_x),
    .cfg_start_y      (cfg_start_y),
    .cfg_end_y        (cfg_end_y),
    .cfg_out_x_res    (cfg_out_x_res),
    .cfg_out_y_res    (cfg_out_y_res),
    .cfg_nearest      (cfg_nearest),
    .cfg_wr           (cfg_wr),
    .frame_start      (frame_start),
    .cfg_busy         (cfg_busy),
    .cfg_err          (cfg_err),
    .cfg_pending      (cfg_pending),
    .cfg_applied      (cfg_applied),
    .scaler_en        (scaler_en),
    .start_x          (start_x),
    .end_x            (end_x),
    .start_y          (start_y),
    .end_y            (end_y),
    .input_x_res      (input_x_res),
    .input_y_res      (input_y_res),
    .output_x_res     (output_x_res),
    .output_y_res     (output_y_res),
    .x_scale          (x_scale),
    .y_scale          (y_scale),
    .nearest_neighbor (nearest_neighbor)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input int sx, input int ex, input int sy, input int ey, input int ox, input int oy, input logic nn);
    cfg_start_x = X_RES_WIDTH'(sx);
    cfg_end_x = X_RES_WIDTH'(ex);
    cfg_start_y = Y_RES_WIDTH'(sy);
    cfg_end_y = Y_RES_WIDTH'(ey);
    cfg_out_x_res = X_RES_WIDTH'(ox);
    cfg_out_y_res = Y_RES_WIDTH'(oy);
    cfg_nearest = nn;
    cfg_wr = 1'b1;
    cyc(1);
    cfg_wr = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_applied", cfg_applied, 0);
    chk("rst_en", scaler_en, 0);
    chk("rst_xscale", x_scale, 0);
    chk("rst_yscale", y_scale, 0);
    chk("rst_endx", end_x, 0);
    chk("rst_outx", output_x_res, 0);
    rst_n = 1'b1;
    cyc(1);
    // upscale 1280x720 -> 1920x1080
    wr(0, 1280, 0, 720, 1919, 1079, 1'b0);
    chk("up_busy_c1", cfg_busy, 1);
    cyc(52);
    chk("up_busy_c53", cfg_busy, 1);
    chk("up_pend_c53", cfg_pending, 0);
    cyc(1);
    chk("up_busy_c54", cfg_busy, 0);
    chk("up_pend_c54", cfg_pending, 1);
    chk("up_en_pre", scaler_en, 0);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("up_applied", cfg_applied, 1);
    chk("up_xscale", x_scale, 'h2AAA);
    chk("up_yscale", y_scale, 'h2AAA);
    chk("up_inx", input_x_res, 1279);
    chk("up_iny", input_y_res, 719);
    chk("up_endx", end_x, 1280);
    chk("up_outx", output_x_res, 1919);
    chk("up_en", scaler_en, 1);
    chk("up_pend_off", cfg_pending, 0);
    cyc(1);
    chk("up_applied_1pulse", cfg_applied, 0);
    // identity
    wr(0, 1920, 0, 1080, 1919, 1079, 1'b1);
    cyc(53);
    chk("id_pend", cfg_pending, 1);
    chk("id_xscale_hold", x_scale, 'h2AAA);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("id_applied", cfg_applied, 1);
    chk("id_xscale", x_scale, 'h4000);
    chk("id_yscale", y_scale, 'h4000);
    chk("id_nn", nearest_neighbor, 1);
    chk("id_inx", input_x_res, 1919);
    // scale overflow: 1920 >= 16*100
    wr(0, 1920, 0, 1080, 99, 1079, 1'b0);
    chk("ovf_busy_c1", cfg_busy, 1);
    cyc(1);
    chk("ovf_err", cfg_err, 1);
    chk("ovf_busy_c2", cfg_busy, 0);
    chk("ovf_pend", cfg_pending, 0);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("ovf_no_apply", cfg_applied, 0);
    chk("ovf_xscale_hold", x_scale, 'h4000);
    // just below overflow; mid-division frame_start and ignored cfg_wr
    wr(0, 1599, 0, 720, 99, 1079, 1'b0);
    cyc(1);
    chk("edge_err_clr", cfg_err, 0);
    cyc(8);
    chk("edge_busy_c10", cfg_busy, 1);
    wr(0, 1280, 0, 720, 1919, 1079, 1'b1);
    cyc(19);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("edge_mid_no_apply", cfg_applied, 0);
    cyc(23);
    chk("edge_pend_c54", cfg_pending, 1);
    cyc(26);
    chk("edge_pend_c80", cfg_pending, 1);
    chk("edge_xscale_hold", x_scale, 'h4000);
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("edge_applied_c81", cfg_applied, 1);
    chk("edge_xscale", x_scale, 'h3FF5C);
    chk("edge_yscale", y_scale, 'h2AAA);
    chk("edge_inx", input_x_res, 1598);
    chk("edge_outx", output_x_res, 99);
    chk("edge_nn", nearest_neighbor, 0);
    // empty window
    wr(100, 100, 0, 720, 1919, 1079, 1'b0);
    cyc(1);
    chk("win_err", cfg_err, 1);
    // rewrite in PEND, then frame_start beats a coincident cfg_wr
    wr(0, 1280, 0, 720, 1919, 1079, 1'b0);
    cyc(1);
    chk("win_err_clr", cfg_err, 0);
    cyc(52);
    chk("rw_pend", cfg_pending, 1);
    wr(0, 1920, 0, 1080, 1919, 1079, 1'b1);
    chk("rw_busy", cfg_busy, 1);
    chk("rw_pend_drop", cfg_pending, 0);
    chk("rw_no_apply", cfg_applied, 0);
    cyc(53);
    chk("rw_pend2", cfg_pending, 1);
    frame_start = 1'b1;
    wr(0, 1280, 0, 720, 1919, 1079, 1'b0);
    frame_start = 1'b0;
    chk("rw_applied", cfg_applied, 1);
    chk("rw_xscale", x_scale, 'h4000);
    chk("rw_nn", nearest_neighbor, 1);
    chk("rw_wr_ignored", cfg_busy, 0);
    // overflow at equality: 1600 == 16*100
    wr(0, 1600, 0, 720, 99, 1079, 1'b0);
    cyc(1);
    chk("eq_err", cfg_err, 1);
    chk("eq_xscale_hold", x_scale, 'h4000);
    // reset while pending
    wr(0, 1280, 0, 720, 1919, 1079, 1'b0);
    cyc(53);
    chk("rp_pend", cfg_pending, 1);
    rst_n = 1'b0;
    #1;
    chk("rp_pend_clr", cfg_pending, 0);
    chk("rp_en_clr", scaler_en, 0);
    chk("rp_xscale_clr", x_scale, 0);
    chk("rp_endx_clr", end_x, 0);
    chk("rp_nn_clr", nearest_neighbor, 0);
    chk("rp_busy_clr", cfg_busy, 0);
    cyc(1);
    rst_n = 1'b1;
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
    chk("rp_no_apply", cfg_applied, 0);
    chk("rp_en_off", scaler_en, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
